// File: rtl/csa_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// csa_seq_ctrl_if
//
// Bundles every signal of the chunked-adder sequencer apart from clk/rst_n:
// the request side (start, operands, result, status) and the side that faces
// the shared combinational carry-select adder.
//
// Handshake: start is a single-sided request. It is accepted on a rising
// clk edge when the controller is not busy (IDLE or DONE state); while busy=1
// start is ignored. Acceptance is not acknowledged separately: busy rising
// after the edge is the acknowledgement, and done pulses for exactly one
// cycle when sum/cout hold the finished result.
//
// Signals:
//   start     request to begin an addition
//   a, b      N-bit operands, N = W*CHUNKS
//   cin       carry into chunk 0
//   busy      high while chunks are being processed
//   done      one-cycle pulse when the result is valid
//   sum       registered N-bit result
//   cout      registered carry out of the top chunk
//   add_a     W-bit chunk of A driven to the shared adder
//   add_b     W-bit chunk of B driven to the shared adder
//   add_cin   carry-in driven to the shared adder
//   add_sum   W-bit sum returned by the adder (combinational)
//   add_cout  carry-out returned by the adder
//
// Modports:
//   slave   the sequencer itself
//   master  the environment (requester plus adder instance)
// ---------------------------------------------------------------------------
interface csa_seq_ctrl_if #(
    parameter int W      = 6,
    parameter int CHUNKS = 4
);
    localparam int N = W * CHUNKS;

    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic         add_cin;
    logic [W-1:0] add_sum;
    logic         add_cout;

    modport slave (
        input  start,
        input  a,
        input  b,
        input  cin,
        output busy,
        output done,
        output sum,
        output cout,
        output add_a,
        output add_b,
        output add_cin,
        input  add_sum,
        input  add_cout
    );

    modport master (
        output start,
        output a,
        output b,
        output cin,
        input  busy,
        input  done,
        input  sum,
        input  cout,
        input  add_a,
        input  add_b,
        input  add_cin,
        output add_sum,
        output add_cout
    );
endinterface

// File: rtl/csa_seq_ctrl.sv
// ---------------------------------------------------------------------------
// csa_seq_ctrl
//
// Sequencing controller that reuses one W-bit combinational carry-select
// adder to add two N-bit operands (N = W*CHUNKS), one chunk per clock,
// least-significant chunk first. The carry out of each chunk is registered
// and fed back as the carry into the next chunk.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   bus        csa_seq_ctrl_if.slave: request, result and adder signals
//   fsm_state  current FSM state (0 IDLE, 1 RUN, 2 DONE) for observation
//
// Timing (CHUNKS=4): start accepted at edge E0, chunk k captured at edge
// E(k+1), done high during the cycle between E4 and E5. A start seen in the
// DONE cycle is accepted at once, so operations can run back to back.
// ---------------------------------------------------------------------------
module csa_seq_ctrl #(
    parameter int W      = 6,
    parameter int CHUNKS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    csa_seq_ctrl_if.slave       bus,
    output logic [1:0]          fsm_state
);
    localparam int N  = W * CHUNKS;
    localparam int IW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    localparam logic [IW-1:0] LAST = IW'(CHUNKS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic          carry_reg;
    logic          accept;

    // A request is only taken when no operation is in flight. DONE counts as
    // free so a new operation can follow without an idle bubble.
    assign accept = bus.start && ((state == S_IDLE) || (state == S_DONE));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            bus.sum   <= '0;
            bus.cout  <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    bus.sum[int'(idx)*W +: W] <= bus.add_sum;
                    carry_reg                 <= bus.add_cout;
                    if (idx == LAST) begin
                        bus.cout <= bus.add_cout;
                        // Return idx to 0 explicitly so it stays in range
                        // even when CHUNKS is not a power of two.
                        idx      <= '0;
                        state    <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    // IDLE, DONE, and any unused encoding.
                    if (accept) begin
                        a_reg     <= bus.a;
                        b_reg     <= bus.b;
                        carry_reg <= bus.cin;
                        bus.sum   <= '0;
                        bus.cout  <= 1'b0;
                        idx       <= '0;
                        state     <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Adder inputs are only meaningful in RUN; elsewhere they are held at 0
    // so the shared adder sees a quiet, known input.
    always_comb begin
        bus.add_a   = '0;
        bus.add_b   = '0;
        bus.add_cin = 1'b0;
        if (state == S_RUN) begin
            bus.add_a   = a_reg[int'(idx)*W +: W];
            bus.add_b   = b_reg[int'(idx)*W +: W];
            bus.add_cin = carry_reg;
        end
    end

    assign bus.busy  = (state == S_RUN);
    assign bus.done  = (state == S_DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_csa_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csa_seq_ctrl
//
// Bench for csa_seq_ctrl. The shared adder is modelled here as a plain
// W-bit add. Expected {cout,sum} values come from a full-width a+b+cin and
// are queued when an operation is started, then popped when done pulses.
// ---------------------------------------------------------------------------
module tb_csa_seq_ctrl;
    localparam int W      = 6;
    localparam int CHUNKS = 4;
    localparam int N      = W * CHUNKS;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;

    logic       clk;
    logic       rst_n;
    logic [1:0] fsm_state;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;

    logic [N:0] exp_q[$];

    csa_seq_ctrl_if #(.W(W), .CHUNKS(CHUNKS)) bif ();

    csa_seq_ctrl #(.W(W), .CHUNKS(CHUNKS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bif),
        .fsm_state (fsm_state)
    );

    // Shared combinational adder.
    assign {bif.add_cout, bif.add_sum} = {1'b0, bif.add_a} + {1'b0, bif.add_b}
                                       + {{W{1'b0}}, bif.add_cin};

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (bif.done === 1'b1) done_cnt = done_cnt + 1;
    end

    // Hard stop in case something never finishes.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    // Let the DUT fall back to IDLE with start low.
    task automatic go_idle();
        bif.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Start one operation (called #1 after an edge, DUT in IDLE or DONE),
    // check every RUN cycle against a chunk model, then check the result
    // in the done cycle. Returns #1 after the edge that entered DONE.
    task automatic run_op(input logic [N-1:0] va, input logic [N-1:0] vb, input logic vc);
        logic [N:0]   full;
        logic [N:0]   want;
        logic [W-1:0] ca[CHUNKS];
        logic [W-1:0] cb[CHUNKS];
        logic         cc[CHUNKS];
        logic         c;
        logic [W:0]   part;
        full = {1'b0, va} + {1'b0, vb} + {{N{1'b0}}, vc};
        c = vc;
        for (int k = 0; k < CHUNKS; k++) begin
            ca[k] = W'(va >> (k * W));
            cb[k] = W'(vb >> (k * W));
            cc[k] = c;
            part  = {1'b0, ca[k]} + {1'b0, cb[k]} + {{W{1'b0}}, c};
            c     = part[W];
        end
        exp_q.push_back(full);
        bif.a     = va;
        bif.b     = vb;
        bif.cin   = vc;
        bif.start = 1'b1;
        for (int k = 0; k < CHUNKS; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                // Scramble inputs after capture: they must not matter.
                bif.start = 1'b0;
                bif.a     = N'($urandom);
                bif.b     = N'($urandom);
                bif.cin   = 1'($urandom_range(0, 1));
            end
            checks++;
            if (bif.busy !== 1'b1 || bif.done !== 1'b0 || fsm_state !== S_RUN) begin
                errors++;
                $display("FAIL run_status k=%0d: busy=%b done=%b state=%0d, required busy=1 done=0 state=1",
                         k, bif.busy, bif.done, fsm_state);
            end
            checks++;
            if (bif.add_a !== ca[k] || bif.add_b !== cb[k] || bif.add_cin !== cc[k]) begin
                errors++;
                $display("FAIL run_chunk k=%0d: add_a=%h add_b=%h add_cin=%b, required %h %h %b",
                         k, bif.add_a, bif.add_b, bif.add_cin, ca[k], cb[k], cc[k]);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (bif.done !== 1'b1 || bif.busy !== 1'b0) begin
            errors++;
            $display("FAIL done_cycle: done=%b busy=%b, required done=1 busy=0", bif.done, bif.busy);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL result_queue: got {cout,sum}=%h with no expected entry", {bif.cout, bif.sum});
        end else begin
            want = exp_q.pop_front();
            if ({bif.cout, bif.sum} !== want) begin
                errors++;
                $display("FAIL result a=%h b=%h cin=%b: cout=%b sum=%h, required cout=%b sum=%h",
                         va, vb, vc, bif.cout, bif.sum, want[N], want[N-1:0]);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        bif.start = 1'b1;
        bif.a     = 24'hFFFFFF;
        bif.b     = 24'hFFFFFF;
        bif.cin   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bif.busy !== 1'b0 || bif.done !== 1'b0 || fsm_state !== S_IDLE) begin
            errors++;
            $display("FAIL reset_status: busy=%b done=%b state=%0d, required 0 0 0", bif.busy, bif.done, fsm_state);
        end
        checks++;
        if (bif.sum !== 24'h0 || bif.cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_result: sum=%h cout=%b, required 000000 0", bif.sum, bif.cout);
        end
        checks++;
        if (bif.add_a !== 6'h0 || bif.add_b !== 6'h0 || bif.add_cin !== 1'b0) begin
            errors++;
            $display("FAIL reset_adder_in: add_a=%h add_b=%h add_cin=%b, required 00 00 0",
                     bif.add_a, bif.add_b, bif.add_cin);
        end
        bif.start = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bif.busy !== 1'b0 || fsm_state !== S_IDLE) begin
            errors++;
            $display("FAIL reset_release: busy=%b state=%0d, required 0 0", bif.busy, fsm_state);
        end
    endtask

    task automatic test_ripple();
        run_op(24'hFFFFFF, 24'h000001, 1'b0);
        checks++;
        if (bif.sum !== 24'h000000 || bif.cout !== 1'b1) begin
            errors++;
            $display("FAIL ripple_literal: sum=%h cout=%b, required 000000 1", bif.sum, bif.cout);
        end
        bif.start = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bif.done !== 1'b0 || fsm_state !== S_IDLE) begin
            errors++;
            $display("FAIL ripple_done_width: done=%b state=%0d, required done=0 state=0", bif.done, fsm_state);
        end
        checks++;
        if (bif.sum !== 24'h000000 || bif.cout !== 1'b1) begin
            errors++;
            $display("FAIL ripple_hold: sum=%h cout=%b, required 000000 1", bif.sum, bif.cout);
        end
    endtask

    task automatic test_carry_in();
        go_idle();
        run_op(24'h123456, 24'h654321, 1'b1);
        checks++;
        if (bif.sum !== 24'h777778 || bif.cout !== 1'b0) begin
            errors++;
            $display("FAIL carry_in_literal: sum=%h cout=%b, required 777778 0", bif.sum, bif.cout);
        end
    endtask

    task automatic test_random();
        // Corner vectors first, then random ones; all run back to back.
        run_op(24'h000000, 24'h000000, 1'b0);
        run_op(24'hFFFFFF, 24'hFFFFFF, 1'b1);
        run_op(24'h03F03F, 24'h000FC1, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            run_op(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_start_during_run();
        int d0;
        logic [N:0] want;
        go_idle();
        d0 = done_cnt;
        exp_q.push_back({1'b0, 24'h001000});
        bif.a = 24'h000FFF; bif.b = 24'h000001; bif.cin = 1'b0; bif.start = 1'b1;
        @(posedge clk); #1;              // E0
        bif.start = 1'b0;
        @(posedge clk); #1;              // E1
        bif.a = 24'h0; bif.b = 24'h0; bif.start = 1'b1;
        @(posedge clk); #1;              // E2: start ignored
        bif.start = 1'b0;
        @(posedge clk); #1;              // E3
        @(posedge clk); #1;              // E4
        checks++;
        if (bif.done !== 1'b1) begin
            errors++;
            $display("FAIL sdr_done: done=%b, required 1", bif.done);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sdr_queue: no expected entry");
        end else begin
            want = exp_q.pop_front();
            if ({bif.cout, bif.sum} !== want) begin
                errors++;
                $display("FAIL sdr_result: cout=%b sum=%h, required cout=%b sum=%h",
                         bif.cout, bif.sum, want[N], want[N-1:0]);
            end
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (done_cnt !== d0 + 1) begin
            errors++;
            $display("FAIL sdr_single_done: done pulses=%0d, required %0d", done_cnt - d0, 1);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        go_idle();
        d0 = done_cnt;
        bif.a = 24'h000FFF; bif.b = 24'h000001; bif.cin = 1'b0; bif.start = 1'b1;
        @(posedge clk); #1;              // E0
        bif.start = 1'b0;
        @(posedge clk); #1;              // E1: chunk 0 already in sum
        rst_n = 1'b0;
        @(posedge clk); #1;              // E2: reset
        checks++;
        if (fsm_state !== S_IDLE || bif.busy !== 1'b0 || bif.sum !== 24'h0 || bif.cout !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: state=%0d busy=%b sum=%h cout=%b, required 0 0 000000 0",
                     fsm_state, bif.busy, bif.sum, bif.cout);
        end
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (done_cnt !== d0) begin
            errors++;
            $display("FAIL mid_reset_no_done: done pulses=%0d, required 0", done_cnt - d0);
        end
        run_op(24'hABCDEF, 24'h123456, 1'b1);
    endtask

    task automatic test_back_to_back();
        go_idle();
        run_op(24'h000001, 24'h000001, 1'b0);
        // Now in the DONE cycle: issue the next start immediately. run_op
        // checks busy/state=RUN right after the next edge.
        run_op(24'h000002, 24'h000003, 1'b0);
        checks++;
        if (bif.sum !== 24'h000005 || bif.cout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_literal: sum=%h cout=%b, required 000005 0", bif.sum, bif.cout);
        end
        go_idle();
    endtask

    // ---------------- sequence ----------------
    initial begin
        rst_n     = 1'b0;
        bif.start = 1'b0;
        bif.a     = '0;
        bif.b     = '0;
        bif.cin   = 1'b0;
        test_reset();
        test_ripple();
        test_carry_in();
        test_random();
        test_start_during_run();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_empty: %0d expected results never produced", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
